pong_score_keeper: RTL and testbench
====================================

# pong_score_keeper

Tracks both players' scores from ball-exit events, enforces a post-point serve pause, and detects the winning score. Its `game_end` output is the game-over flag that the game reset logic ANDs with the player restart input to generate a soft reset. It sits between the ball/collision logic, which supplies the exit events, and the display and reset logic, which consume the scores and `game_end`.

## Interface
- `WIN_SCORE`, default 7: score that ends the game; legal range 1..15.
- `SERVE_CYCLES`, default 50_000_000: length of the serve pause in clock cycles (1 s at 50 MHz); must be ≥ 1.
- `CNT_W`, default 26: serve counter width; must satisfy 2^CNT_W > SERVE_CYCLES.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `point_left`  in  1  level; high while the ball is past the right wall (left player scores).
- `point_right`  in  1  level; high while the ball is past the left wall (right player scores).
- `score_left`  out  4  left player score.
- `score_right`  out  4  right player score.
- `serve_hold`  out  1  high while the ball must be frozen at centre.
- `game_end`  out  1  high once either score reaches `WIN_SCORE`.
- `winner`  out  1  0 = left won, 1 = right won; valid only while `game_end` = 1.

## Operation
- **Edge detection.** Each point input is registered into `pl_q` / `pr_q`. An event is `point & ~point_q`.
  - Both `_q` registers reset to 1, so an input that is already high at reset release never counts.
- **States:** SERVE, PLAY, OVER.
- **SERVE**
  - Entered with the counter loaded to `SERVE_CYCLES-1`; `serve_hold` = 1.
  - The counter decrements every cycle.
  - On the cycle the counter equals 0: go to PLAY, `serve_hold` → 0.
  - Point events in SERVE are ignored; the edge registers still track the inputs.
- **PLAY**
  - Single left event: `score_left` += 1. If the new value equals `WIN_SCORE`, go to OVER with `winner` = 0; otherwise go to SERVE and reload the counter.
  - Single right event: the mirror case, with `winner` = 1.
  - Both events in the same cycle: both are ignored, the scores are unchanged, and the block stays in PLAY.
- **OVER**
  - `game_end` = 1 and `serve_hold` = 1.
  - Scores and `winner` are frozen; all events are ignored.
  - Only `reset` leaves OVER.
- Scores never exceed `WIN_SCORE`, so no 4-bit wrap can occur.
- **Reset values:** `score_left` = 0, `score_right` = 0, `game_end` = 0, `winner` = 0, `serve_hold` = 1, state = SERVE, counter = `SERVE_CYCLES-1`, `pl_q` = `pr_q` = 1.
- **Reset mid-operation:** asserting `reset` in any state immediately forces the reset values. No partial score survives.

## Timing
- All outputs are registered.
- **Point latency:** the input rises before edge N; the score, `game_end`, `winner` and `serve_hold` all update at edge N, so they are visible one cycle after the input first reads high.
- **Serve pause:** `serve_hold` stays high for exactly `SERVE_CYCLES` cycles. It is counted from the edge that entered SERVE, or from the first edge after reset release.
  - An event at the edge that ends SERVE is not counted, because the state was still SERVE.
  - The first countable event is at the edge after `serve_hold` reads 0.
- **Holding an input:** a point input held high across many cycles counts once. It must fall and rise again to count again.
- **Game end:** `game_end` rises on the same edge as the winning score. It stays high until `reset`.

## Test plan
All scenarios use `WIN_SCORE` = 3 and `SERVE_CYCLES` = 4.
- **Reset/serve:** release `reset` → `serve_hold` = 1 for 4 cycles then 0; both scores 0; `game_end` = 0.
- **Single point:** in PLAY, hold `point_left` high for 10 cycles → `score_left` = 1 one cycle later, counted once; `serve_hold` high for 4 cycles.
- **Ignored events:** pulse `point_right` during SERVE → no change. Pulse both points in the same PLAY cycle → scores unchanged, state stays PLAY.
- **Right win:** right scores 3 times (with serve pauses) → after the third event `score_right` = 3, `game_end` = 1, `winner` = 1, `serve_hold` = 1. Further pulses leave `score_left` / `score_right` unchanged.
- **Reset mid-game:** at score 2–1, assert `reset` for one cycle mid-SERVE → all outputs return to reset values immediately; a subsequent serve lasts 4 cycles.
- **Point high at reset:** `point_left` high during and after reset release → no score increment until the input falls and rises again in PLAY.

Source files
------------

// File: rtl/pong_score_keeper.sv
// Pong score keeper: counts edge-detected ball-exit events, inserts a serve pause
// after every point and latches the game-over condition with the winning side.
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_left,
  input  logic       point_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       serve_hold,
  output logic       game_end,
  output logic       winner
);

  localparam logic [3:0]       WinScore = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CntLoad  = CNT_W'(SERVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {StServe, StPlay, StOver} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic             winner_q, winner_d;
  logic             pl_q, pr_q;
  logic             serve_hold_q, serve_hold_d;
  logic             game_end_q, game_end_d;
  logic             ev_l, ev_r;

  assign ev_l = point_left  & ~pl_q;
  assign ev_r = point_right & ~pr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StServe;
      cnt_q        <= CntLoad;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      winner_q     <= 1'b0;
      // Reset high so an input already asserted at release is not an event.
      pl_q         <= 1'b1;
      pr_q         <= 1'b1;
      serve_hold_q <= 1'b1;
      game_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      pl_q         <= point_left;
      pr_q         <= point_right;
      serve_hold_q <= serve_hold_d;
      game_end_q   <= game_end_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    unique case (state_q)
      StServe: begin
        if (cnt_q == '0) begin
          state_d = StPlay;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPlay: begin
        // Simultaneous events cancel: neither side is credited.
        if (ev_l && !ev_r) begin
          score_l_d = score_l_q + 4'd1;
          if (score_l_d == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b0;
          end else begin
            state_d = StServe;
            cnt_d   = CntLoad;
          end
        end else if (ev_r && !ev_l) begin
          score_r_d = score_r_q + 4'd1;
          if (score_r_d == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b1;
          end else begin
            state_d = StServe;
            cnt_d   = CntLoad;
          end
        end
      end
      StOver: begin
        state_d = StOver;
      end
      default: begin
        state_d = StServe;
        cnt_d   = CntLoad;
      end
    endcase
  end

  always_comb begin
    serve_hold_d = (state_d != StPlay);
    game_end_d   = (state_d == StOver);
  end

  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign serve_hold  = serve_hold_q;
  assign game_end    = game_end_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with WIN_SCORE=3, SERVE_CYCLES=4.
module tb_pong_score_keeper;

  logic       clk;
  logic       reset;
  logic       point_left;
  logic       point_right;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       serve_hold;
  logic       game_end;
  logic       winner;

  int n_checks;
  int n_pass;

  pong_score_keeper #(
    .WIN_SCORE   (3),
    .SERVE_CYCLES(4),
    .CNT_W       (3)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .point_left (point_left),
    .point_right(point_right),
    .score_left (score_left),
    .score_right(score_right),
    .serve_hold (serve_hold),
    .game_end   (game_end),
    .winner     (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int sl, input int sr, input int sh,
                           input int ge, input int w);
    check({tag, ".score_left"},  32'(score_left),  32'(sl));
    check({tag, ".score_right"}, 32'(score_right), 32'(sr));
    check({tag, ".serve_hold"},  32'(serve_hold),  32'(sh));
    check({tag, ".game_end"},    32'(game_end),    32'(ge));
    check({tag, ".winner"},      32'(winner),      32'(w));
  endtask

  // Single-cycle pulse followed by SERVE_CYCLES idle cycles to get back to PLAY.
  task automatic score_and_serve(input logic left);
    if (left) point_left = 1'b1;
    else      point_right = 1'b1;
    step();
    point_left  = 1'b0;
    point_right = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b1;
    point_left  = 1'b0;
    point_right = 1'b0;
    step();
    step();
    check_all("reset", 0, 0, 1, 0, 0);

    // Serve after reset release: high before edge 1 and after edges 1..3, low after edge 4.
    reset = 1'b0;
    check("serve0.hold", 32'(serve_hold), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("serve%0d.hold", i), 32'(serve_hold), (i < 4) ? 32'd1 : 32'd0);
    end
    check_all("play0", 0, 0, 0, 0, 0);

    // Left held for 10 cycles scores once; serve pause of 4 cycles.
    point_left = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("hold%0d.score_left", i), 32'(score_left), 32'd1);
      check($sformatf("hold%0d.serve_hold", i), 32'(serve_hold), (i <= 4) ? 32'd1 : 32'd0);
    end
    point_left = 1'b0;
    step();

    // Both events in the same PLAY cycle are ignored.
    point_left  = 1'b1;
    point_right = 1'b1;
    step();
    check_all("both", 1, 0, 0, 0, 0);
    point_left  = 1'b0;
    point_right = 1'b0;
    step();
    check_all("both_after", 1, 0, 0, 0, 0);

    // Right point, then a right pulse inside SERVE is ignored.
    point_right = 1'b1;
    step();
    check_all("r1", 1, 1, 1, 0, 0);
    point_right = 1'b0;
    step();
    point_right = 1'b1;
    step();
    check("serve_pulse.score_right", 32'(score_right), 32'd1);
    point_right = 1'b0;
    step();
    step();
    check_all("r1_play", 1, 1, 0, 0, 0);

    // Second right point; a rise at the edge that ends SERVE does not count.
    point_right = 1'b1;
    step();
    check_all("r2", 1, 2, 1, 0, 0);
    point_right = 1'b0;
    step();
    step();
    step();
    point_right = 1'b1;
    step();
    check_all("serve_end_edge", 1, 2, 0, 0, 0);
    step();
    check_all("held_in_play", 1, 2, 0, 0, 0);
    point_right = 1'b0;
    step();

    // Third right point wins.
    point_right = 1'b1;
    step();
    check_all("r_win", 1, 3, 1, 1, 1);
    point_right = 1'b0;
    step();
    point_left  = 1'b1;
    point_right = 1'b1;
    step();
    point_right = 1'b0;
    step();
    point_left  = 1'b0;
    point_right = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_all("over_frozen", 1, 3, 1, 1, 1);
    point_right = 1'b0;

    // Asynchronous reset from OVER, then build 2-1.
    reset = 1'b1;
    #1;
    check_all("reset_over", 0, 0, 1, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("play1.serve_hold", 32'(serve_hold), 32'd0);
    score_and_serve(1'b1);
    score_and_serve(1'b1);
    point_right = 1'b1;
    step();
    check_all("two_one", 2, 1, 1, 0, 0);
    point_right = 1'b0;
    step();

    // Reset mid-SERVE with point_left held high through release.
    point_left = 1'b1;
    reset      = 1'b1;
    #1;
    check_all("reset_mid", 0, 0, 1, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("reserve%0d.hold", i), 32'(serve_hold), (i < 4) ? 32'd1 : 32'd0);
    end
    step();
    step();
    check_all("held_from_reset", 0, 0, 0, 0, 0);
    point_left = 1'b0;
    step();
    point_left = 1'b1;
    step();
    check_all("rearmed", 1, 0, 1, 0, 0);
    point_left = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
